mem_stage: RTL and testbench

Memory stage and MEM/WB pipeline register of the five-stage processor. It accepts the EX/MEM bundle, performs word loads and stores against an internal data memory with configurable access latency, and stalls upstream while an access is in flight. It registers the result bundle that the write-back stage consumes: `readDataW`, `ALUOutW`, `memToRegW`, `regWriteW` and `writeRegW`.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_stage_if.sv | 18 +
 rtl/data_memory.sv | 18 +
 rtl/mem_stage.sv | 97 +++++++++
 tb/tb_mem_stage.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, FSM states and the MEM/WB bundle for the memory stage
package mem_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W = 5;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic              valid;
        logic              memToReg;
        logic              regWrite;
        logic [WORD_W-1:0] readData;
        logic [WORD_W-1:0] aluOut;
        logic [REG_W-1:0]  writeReg;
        logic              alignErr;
    } memWb_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, stall back-pressure and MEM/WB outputs of the memory stage
interface mem_stage_if;
    import mem_pkg::*;
    logic              validM, memToRegM, memWriteM, regWriteM, flushM;
    logic [WORD_W-1:0] ALUOutM, writeDataM;
    logic [REG_W-1:0]  writeRegM;
    logic              memStallM, validW, memToRegW, regWriteW, alignErrW;
    logic [WORD_W-1:0] readDataW, ALUOutW;
    logic [REG_W-1:0]  writeRegW;
    modport master (
        output validM, memToRegM, memWriteM, regWriteM, flushM, ALUOutM, writeDataM, writeRegM,
        input  memStallM, validW, memToRegW, regWriteW, alignErrW, readDataW, ALUOutW, writeRegW
    );
    modport slave (
        input  validM, memToRegM, memWriteM, regWriteM, flushM, ALUOutM, writeDataM, writeRegM,
        output memStallM, validW, memToRegW, regWriteW, alignErrW, readDataW, ALUOutW, writeRegW
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: word array with synchronous write and asynchronous read, never reset
module data_memory import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    // commit a store at the clock edge
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory access FSM with configurable latency and the MEM/WB pipeline register
module mem_stage import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int LATENCY = 1
) (
    input logic        clk,
    input logic        rst_n,
    mem_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    state_t            state, stateNext;
    logic [CW-1:0]     cnt, cntNext;
    memWb_t            wb, wbNext, req, reqNext, inWb;
    logic              reqStore, reqStoreNext;
    logic [WORD_W-1:0] reqData, reqDataNext, wdata, rdata;
    logic [AW-1:0]     idx;
    logic              memOp, misAl, aligned, busy, done, we;
    assign memOp   = bus.validM & (bus.memToRegM | bus.memWriteM);
    assign misAl   = memOp & (bus.ALUOutM[1:0] != 2'b0);
    assign aligned = memOp & ~misAl;
    assign busy    = state == BUSY;
    assign done    = busy & (cnt == CW'(1));
    data_memory #(.DEPTH(DEPTH)) dmem (.clk(clk), .we(we & rst_n), .addr(idx), .wdata(wdata), .rdata(rdata));
    // MEM/WB bundle for the incoming instruction; a misaligned op never writes the register file
    always_comb begin
        inWb = '0;
        inWb.valid    = bus.validM;
        inWb.memToReg = bus.validM & bus.memToRegM;
        inWb.regWrite = bus.validM & bus.regWriteM & ~misAl;
        inWb.aluOut   = bus.validM ? bus.ALUOutM : '0;
        inWb.writeReg = bus.validM ? bus.writeRegM : '0;
        inWb.alignErr = misAl;
    end
    // next state, request latch and MEM/WB contents; flush aborts anything pending into a bubble
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        reqNext      = req;
        reqStoreNext = reqStore;
        reqDataNext  = reqData;
        wbNext       = '0;
        we           = 1'b0;
        idx          = busy ? req.aluOut[AW+1:2] : bus.ALUOutM[AW+1:2];
        wdata        = busy ? reqData : bus.writeDataM;
        if (bus.flushM) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else if (busy) begin
            if (done) begin
                stateNext       = IDLE;
                cntNext         = '0;
                we              = reqStore;
                wbNext          = req;
                wbNext.readData = req.memToReg ? rdata : '0;
            end else begin
                cntNext = cnt - CW'(1);
            end
        end else if (aligned && LATENCY > 1) begin
            stateNext    = BUSY;
            cntNext      = CW'(LATENCY - 1);
            reqNext      = inWb;
            reqStoreNext = bus.memWriteM;
            reqDataNext  = bus.writeDataM;
        end else begin
            wbNext          = inWb;
            wbNext.readData = (aligned & bus.memToRegM) ? rdata : '0;
            we              = aligned & bus.memWriteM;
        end
        bus.memStallM = rst_n & ~bus.flushM & ((~busy & aligned & (LATENCY > 1)) | (busy & ~done));
    end
    // state, counter, request latch and MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            req      <= '0;
            reqStore <= 1'b0;
            reqData  <= '0;
            wb       <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            req      <= reqNext;
            reqStore <= reqStoreNext;
            reqData  <= reqDataNext;
            wb       <= wbNext;
        end
    end
    assign bus.validW    = wb.valid;
    assign bus.memToRegW = wb.memToReg;
    assign bus.regWriteW = wb.regWrite;
    assign bus.readDataW = wb.readData;
    assign bus.ALUOutW   = wb.aluOut;
    assign bus.writeRegW = wb.writeReg;
    assign bus.alignErrW = wb.alignErr;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of the memory stage at LATENCY 1 and LATENCY 3
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst3_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    mem_stage_if b1();
    mem_stage_if b3();
    mem_stage #(.DEPTH(256), .LATENCY(1)) d1 (.clk(clk), .rst_n(rst1_n), .bus(b1.slave));
    mem_stage #(.DEPTH(256), .LATENCY(3)) d3 (.clk(clk), .rst_n(rst3_n), .bus(b3.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drv1(input logic v, ld, st, rw, input logic [31:0] a, d, input logic [4:0] r);
        b1.validM = v; b1.memToRegM = ld; b1.memWriteM = st; b1.regWriteM = rw;
        b1.ALUOutM = a; b1.writeDataM = d; b1.writeRegM = r; b1.flushM = 1'b0;
    endtask

    task automatic drv3(input logic v, ld, st, rw, input logic [31:0] a, d, input logic [4:0] r);
        b3.validM = v; b3.memToRegM = ld; b3.memWriteM = st; b3.regWriteM = rw;
        b3.ALUOutM = a; b3.writeDataM = d; b3.writeRegM = r; b3.flushM = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // one LATENCY-1 op: no stall ever, result visible after one edge
    task automatic op1(input string tag, input logic ld, st, rw, input logic [31:0] a, d, input logic [4:0] r);
        drv1(1'b1, ld, st, rw, a, d, r);
        #1 check({tag, "_stall"}, b1.memStallM, 0);
        step();
        check({tag, "_validW"}, b1.validW, 1);
    endtask

    // one aligned LATENCY-3 access: stall for two cycles, bubbles, then the result
    task automatic acc3(input string tag, input logic ld, st, input logic [31:0] a, d, input logic [4:0] r);
        drv3(1'b1, ld, st, ld, a, d, r);
        #1 check({tag, "_stall0"}, b3.memStallM, 1);
        step();
        check({tag, "_stall1"}, b3.memStallM, 1);
        check({tag, "_bub1"}, b3.validW, 0);
        step();
        check({tag, "_stall2"}, b3.memStallM, 0);
        check({tag, "_bub2"}, b3.validW, 0);
        step();
        check({tag, "_validW"}, b3.validW, 1);
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        #1;
        check("rst_validW", b1.validW, 0);
        check("rst_readDataW", b1.readDataW, 0);
        check("rst_ALUOutW", b1.ALUOutW, 0);
        check("rst_stall", b1.memStallM, 0);
        @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        // LATENCY 1: store then load the same word
        op1("st10", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        check("st10_regWriteW", b1.regWriteW, 0);
        check("st10_readDataW", b1.readDataW, 0);
        op1("ld10", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8);
        check("ld10_readDataW", b1.readDataW, 32'hDEADBEEF);
        check("ld10_writeRegW", b1.writeRegW, 8);
        check("ld10_regWriteW", b1.regWriteW, 1);
        check("ld10_memToRegW", b1.memToRegW, 1);
        // plain ALU op passes through
        op1("alu", 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd3);
        check("alu_ALUOutW", b1.ALUOutW, 32'h1234);
        check("alu_writeRegW", b1.writeRegW, 3);
        check("alu_readDataW", b1.readDataW, 0);
        check("alu_memToRegW", b1.memToRegW, 0);
        // misaligned load
        op1("mis1", 1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 5'd4);
        check("mis1_alignErrW", b1.alignErrW, 1);
        check("mis1_regWriteW", b1.regWriteW, 0);
        check("mis1_readDataW", b1.readDataW, 0);
        // address wrap modulo DEPTH words
        op1("st400", 1'b0, 1'b1, 1'b0, 32'h400, 32'hA5, 5'd0);
        op1("ld0", 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd1);
        check("wrap_readDataW", b1.readDataW, 32'hA5);
        // flushed store in IDLE leaves memory untouched and yields a bubble
        op1("st30", 1'b0, 1'b1, 1'b0, 32'h30, 32'h11, 5'd0);
        drv1(1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h77, 5'd0);
        b1.flushM = 1'b1;
        step();
        check("flush1_validW", b1.validW, 0);
        op1("ld30", 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 5'd2);
        check("flush1_readDataW", b1.readDataW, 32'h11);
        // bubble
        drv1(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 32'h0, 5'd9);
        step();
        check("bub_validW", b1.validW, 0);
        check("bub_ALUOutW", b1.ALUOutW, 0);
        check("bub_writeRegW", b1.writeRegW, 0);
        // LATENCY 3: stores and loads with stall
        acc3("st20", 1'b0, 1'b1, 32'h20, 32'h12345678, 5'd0);
        acc3("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 5'd7);
        check("ld20_readDataW", b3.readDataW, 32'h12345678);
        check("ld20_writeRegW", b3.writeRegW, 7);
        check("ld20_regWriteW", b3.regWriteW, 1);
        acc3("st40", 1'b0, 1'b1, 32'h40, 32'h1, 5'd0);
        // flush in the second cycle of a store
        drv3(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h5, 5'd0);
        step();
        check("fl3_stall", b3.memStallM, 1);
        b3.flushM = 1'b1;
        #1 check("fl3_stallFlush", b3.memStallM, 0);
        step();
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check("fl3_validW", b3.validW, 0);
        check("fl3_stallAfter", b3.memStallM, 0);
        @(negedge clk);
        acc3("ld40a", 1'b1, 1'b0, 32'h40, 32'h0, 5'd5);
        check("fl3_readDataW", b3.readDataW, 32'h1);
        // misaligned op does not stall even with latency
        drv3(1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 5'd4);
        #1 check("mis3_stall", b3.memStallM, 0);
        step();
        check("mis3_alignErrW", b3.alignErrW, 1);
        check("mis3_regWriteW", b3.regWriteW, 0);
        // reset mid-BUSY drops the pending store
        drv3(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h99, 5'd0);
        step();
        check("rst3_busyStall", b3.memStallM, 1);
        rst3_n = 1'b0;
        #1;
        check("rst3_stall", b3.memStallM, 0);
        check("rst3_validW", b3.validW, 0);
        check("rst3_alignErrW", b3.alignErrW, 0);
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        rst3_n = 1'b1;
        @(negedge clk);
        acc3("ld40b", 1'b1, 1'b0, 32'h40, 32'h0, 5'd6);
        check("rst3_readDataW", b3.readDataW, 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
